// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares the single-port instruction memory between the Fetch stage
// (read-only) and the program loader / debug port (read/write). The arbiter
// owns the memory address, write-enable and write-data lines. It registers the
// read data, so every accepted access gets its response one cycle later.
// stall_f_o tells the hazard unit that Fetch wanted the memory and did not
// get it.
//
// Arbitration:
//   - The loader normally has priority and may hold the memory across a
//     burst with ld_lock_i.
//   - If Fetch has been denied MAX_WAIT consecutive cycles, it wins. This
//     also breaks a loader lock.
//
// Optional feature:
//   Define IMEM_ARB_RR_EN to make conflicts in IDLE alternate between the
//   two requesters instead of always favouring the loader.
//
// Parameters
//   DEPTH      memory depth in words (word index = addr[$clog2(DEPTH)+1:2])
//   MAX_WAIT   denied Fetch cycles before Fetch is forced to win (1..15)
//
// Ports
//   clk_i           system clock, rising edge
//   reset_i         asynchronous, active-high reset
//   fetch_req_i     Fetch wants the word at fetch_addr_i
//   fetch_addr_i    Fetch byte address (PCF)
//   fetch_gnt_o     combinational, Fetch accepted this cycle
//   fetch_rvalid_o  registered, fetch_rdata_o valid
//   fetch_rdata_o   registered instruction word
//   fetch_misal_o   registered, accepted fetch address was not word aligned
//   stall_f_o       combinational, fetch_req_i & ~fetch_gnt_o
//   ld_req_i        loader request
//   ld_we_i         loader write (1) / read (0)
//   ld_lock_i       keep ownership after this beat
//   ld_addr_i       loader byte address
//   ld_wdata_i      loader write data
//   ld_gnt_o        combinational, loader beat accepted
//   ld_rvalid_o     registered, ld_rdata_o valid (reads only)
//   ld_rdata_o      registered loader read data
//   mem_addr_o      memory word address, {index, 2'b00}
//   mem_we_o        memory write enable
//   mem_wdata_o     memory write data
//   mem_rdata_i     memory combinational read data
// -----------------------------------------------------------------------------

`default_nettype none

module imem_arbiter #(
    parameter int DEPTH    = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_gnt_o,
    output logic        fetch_rvalid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_misal_o,
    output logic        stall_f_o,

    input  logic        ld_req_i,
    input  logic        ld_we_i,
    input  logic        ld_lock_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_wdata_i,
    output logic        ld_gnt_o,
    output logic        ld_rvalid_o,
    output logic [31:0] ld_rdata_o,

    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // state  | meaning
    // IDLE   | no lock held, per-cycle arbitration
    // LOCKED | loader owns the memory for a burst, Fetch denied unless starved
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic        fetch_rvalid_q;
    logic [31:0] fetch_rdata_q;
    logic        fetch_misal_q;
    logic        ld_rvalid_q;
    logic [31:0] ld_rdata_q;

    logic        fetch_gnt;
    logic        ld_gnt;
    logic        conflict;
    logic        starve;
    logic        ld_read;

    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] ld_idx;
    logic [AW-1:0] mem_idx;

`ifdef IMEM_ARB_RR_EN
    // Winner of the most recent IDLE conflict: 0 = Fetch, 1 = loader.
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_LD    = 1'b1;
    logic last_owner_q, last_owner_d;
`endif

    // Only the word index and the fetch byte offset are used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr_i[31:AW+2], ld_addr_i[31:AW+2], ld_addr_i[1:0]};

    assign fetch_idx = fetch_addr_i[AW+1:2];
    assign ld_idx    = ld_addr_i[AW+1:2];

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    assign conflict = fetch_req_i & ld_req_i;
    assign starve   = fetch_req_i & (wait_cnt_q == MAX_WAIT_C);

    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        if (starve) begin
            // Starvation override wins in either state and breaks a lock.
            fetch_gnt = 1'b1;
        end else if (state_q == LOCKED) begin
            ld_gnt = ld_req_i;
        end else if (conflict) begin
`ifdef IMEM_ARB_RR_EN
            if (last_owner_q == OWN_LD) begin
                fetch_gnt = 1'b1;
            end else begin
                ld_gnt = 1'b1;
            end
`else
            ld_gnt = 1'b1;
`endif
        end else begin
            fetch_gnt = fetch_req_i;
            ld_gnt    = ld_req_i;
        end
    end

    assign ld_read = ld_gnt & ~ld_we_i;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 4'd0;

        if (fetch_req_i && !fetch_gnt) begin
            wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (ld_gnt && ld_lock_i) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (fetch_gnt || !ld_req_i || (ld_gnt && !ld_lock_i)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef IMEM_ARB_RR_EN
    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == IDLE && conflict) begin
            last_owner_d = ld_gnt ? OWN_LD : OWN_FETCH;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // State and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            wait_cnt_q     <= 4'd0;
            fetch_rvalid_q <= 1'b0;
            fetch_rdata_q  <= 32'h0;
            fetch_misal_q  <= 1'b0;
            ld_rvalid_q    <= 1'b0;
            ld_rdata_q     <= 32'h0;
`ifdef IMEM_ARB_RR_EN
            last_owner_q   <= OWN_FETCH;
`endif
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            fetch_rvalid_q <= fetch_gnt;
            fetch_misal_q  <= fetch_gnt & (fetch_addr_i[1:0] != 2'b00);
            ld_rvalid_q    <= ld_read;
            if (fetch_gnt) begin
                fetch_rdata_q <= mem_rdata_i;
            end
            if (ld_read) begin
                ld_rdata_q <= mem_rdata_i;
            end
`ifdef IMEM_ARB_RR_EN
            last_owner_q   <= last_owner_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Memory side: the loader drives the address only when granted. Otherwise
    // the Fetch address stays on the bus.
    // -------------------------------------------------------------------------
    assign mem_idx     = ld_gnt ? ld_idx : fetch_idx;
    assign mem_addr_o  = {{(30 - AW){1'b0}}, mem_idx, 2'b00};
    assign mem_we_o    = ld_gnt & ld_we_i;
    assign mem_wdata_o = ld_wdata_i;

    assign fetch_gnt_o    = fetch_gnt;
    assign ld_gnt_o       = ld_gnt;
    assign stall_f_o      = fetch_req_i & ~fetch_gnt;
    assign fetch_rvalid_o = fetch_rvalid_q;
    assign fetch_rdata_o  = fetch_rdata_q;
    assign fetch_misal_o  = fetch_misal_q;
    assign ld_rvalid_o    = ld_rvalid_q;
    assign ld_rdata_o     = ld_rdata_q;

endmodule

`default_nettype wire
